mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 114 +++++++++++
 tb/tb_mem_access_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: IDLE/BUSY/DONE handshake with pipeline stall.
// Define MEM_TIMEOUT_EN to compile in the bus watchdog (TIMEOUT_CYCLES) and bus_err.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] mr,
  input  logic [31:0] mqb,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mdo,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state;
  logic   access;
  logic   aligned;

  assign access  = mm2reg | mwmem;
  assign aligned = (mr[1:0] == 2'b00);

  // DONE releases the pipeline so the retiring instruction advances exactly once.
  always_comb begin
    stall = 1'b0;
    unique case (state)
      StIdle:  stall = access & aligned;
      StBusy:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] watchdog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      watchdog <= 8'd0;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (state == StIdle && access && aligned) begin
        watchdog <= 8'd0;
      end else if (state == StBusy && !mem_ack) begin
        watchdog <= watchdog + 8'd1;
        if (watchdog == 8'(TIMEOUT_CYCLES - 1)) begin
          bus_err <= 1'b1;
        end
      end
    end
  end
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mdo       <= 32'd0;
      addr_err  <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (access) begin
            if (aligned) begin
              state     <= StBusy;
              mem_req   <= 1'b1;
              // A store wins when both flags are set.
              mem_we    <= mwmem;
              mem_addr  <= {mr[31:2], 2'b00};
              mem_wdata <= mqb;
            end else begin
              addr_err <= 1'b1;
            end
          end
        end
        StBusy: begin
          if (mem_ack) begin
            state   <= StDone;
            mem_req <= 1'b0;
            if (!mem_we) begin
              mdo <= mem_rdata;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (watchdog == 8'(TIMEOUT_CYCLES - 1)) begin
            state   <= StDone;
            mem_req <= 1'b0;
          end
`endif
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: table-driven transactions plus reset and watchdog
// sequences; load results flow through a scoreboard queue.
module tb_mem_access_ctrl;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mm2reg, mwmem, mem_ack;
  logic [31:0] mr, mqb, mem_rdata;
  logic        mem_req, mem_we, stall, addr_err, bus_err;
  logic [31:0] mem_addr, mem_wdata, mdo;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .mm2reg    (mm2reg),
    .mwmem     (mwmem),
    .mr        (mr),
    .mqb       (mqb),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mdo       (mdo),
    .stall     (stall),
    .addr_err  (addr_err),
    .bus_err   (bus_err)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] mr;
    logic [31:0] qb;
    logic [31:0] rdata;
    int          delay;  // BUSY cycles before ack, or extra misaligned cycles
    logic        exp_we;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t        vecs[7];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mdo = 32'd0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mm2reg    = 1'b0;
    mwmem     = 1'b0;
    mem_ack   = 1'b0;
    mr        = 32'd0;
    mqb       = 32'd0;
    mem_rdata = 32'd0;
  endtask

  task automatic run_aligned(input vec_t v, input int idx);
    int sc;
    sc = 0;
    mm2reg = v.ld;
    mwmem  = v.st;
    mr     = v.mr;
    mqb    = v.qb;
    #1;
    chk($sformatf("v%0d_idle_stall", idx), 32'(stall), 32'd1);
    sc += int'(stall);
    tick();
    chk($sformatf("v%0d_req", idx), 32'(mem_req), 32'd1);
    chk($sformatf("v%0d_addr", idx), mem_addr, v.exp_addr);
    chk($sformatf("v%0d_we", idx), 32'(mem_we), 32'(v.exp_we));
    if (v.exp_we) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.qb);
    sc += int'(stall);
    for (int k = 0; k < v.delay; k++) begin
      tick();
      chk($sformatf("v%0d_busy_req", idx), 32'(mem_req), 32'd1);
      chk($sformatf("v%0d_busy_addr", idx), mem_addr, v.exp_addr);
      sc += int'(stall);
    end
    mem_ack   = 1'b1;
    mem_rdata = v.rdata;
    if (!v.st) model_mdo = v.rdata;
    exp_q.push_back(model_mdo);
    tick();
    chk($sformatf("v%0d_stall_cycles", idx), 32'(sc), 32'(v.delay + 2));
    // DONE: request still on the inputs and a stray ack must both be ignored.
    mem_rdata = ~v.rdata;
    #1;
    chk($sformatf("v%0d_done_req", idx), 32'(mem_req), 32'd0);
    chk($sformatf("v%0d_done_stall", idx), 32'(stall), 32'd0);
    if (exp_q.size() == 0) begin
      chk($sformatf("v%0d_scoreboard_empty", idx), 32'd0, 32'd1);
    end else begin
      chk($sformatf("v%0d_mdo", idx), mdo, exp_q.pop_front());
    end
    tick();
    chk($sformatf("v%0d_idle_req", idx), 32'(mem_req), 32'd0);
    chk($sformatf("v%0d_mdo_hold", idx), mdo, model_mdo);
    clear_inputs();
    tick();
    chk($sformatf("v%0d_no_reissue", idx), 32'(mem_req), 32'd0);
  endtask

  task automatic run_misaligned(input vec_t v, input int idx);
    for (int k = 0; k <= v.delay; k++) begin
      mm2reg = v.ld;
      mwmem  = v.st;
      mr     = v.mr;
      #1;
      chk($sformatf("v%0d_mis_stall", idx), 32'(stall), 32'd0);
      tick();
      chk($sformatf("v%0d_addr_err", idx), 32'(addr_err), 32'd1);
      chk($sformatf("v%0d_mis_req", idx), 32'(mem_req), 32'd0);
    end
    clear_inputs();
    tick();
    chk($sformatf("v%0d_addr_err_clr", idx), 32'(addr_err), 32'd0);
  endtask

  initial begin
    //          ld    st    mr            qb            rdata         dly we    addr
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        32'hDEAD_BEEF, 1, 1'b0, 32'h0000_0040};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h9999_9999, 0, 1'b1, 32'h0000_0010};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0041, 32'h0,        32'h0,         0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0008, 32'hAAAA_5555, 32'h0BAD_F00D, 0, 1'b1, 32'h0000_0008};
    vecs[4] = '{1'b0, 1'b1, 32'h1000_0006, 32'h0,        32'h0,         2, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'hCAFE_F00D, 3, 1'b0, 32'hFFFF_FFFC};
    vecs[6] = '{1'b1, 1'b0, 32'h8000_0104, 32'h0,        32'h1357_2468, 0, 1'b0, 32'h8000_0104};

    clear_inputs();
    rst = 1'b1;
    #3;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_mdo", mdo, 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    #9;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].mr[1:0] == 2'b00) run_aligned(vecs[i], i);
      else run_misaligned(vecs[i], i);
    end

    // Reset in the middle of BUSY, then a late ack.
    mm2reg = 1'b1;
    mr     = 32'h0000_0020;
    tick();
    chk("mid_rst_busy_req", 32'(mem_req), 32'd1);
    #2;
    rst    = 1'b1;
    mm2reg = 1'b0;
    #1;
    model_mdo = 32'd0;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_mdo", mdo, model_mdo);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    #1;
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    chk("late_ack_mdo", mdo, model_mdo);
    clear_inputs();
    tick();
    chk("late_ack_mdo2", mdo, model_mdo);

    // Transaction with no prompt ack: watchdog fires, or BUSY waits indefinitely.
    mm2reg = 1'b1;
    mr     = 32'h0000_0030;
    tick();
`ifdef MEM_TIMEOUT_EN
    for (int i = 1; i < int'(TO); i++) begin
      chk("wd_busy_req", 32'(mem_req), 32'd1);
      chk("wd_busy_bus_err", 32'(bus_err), 32'd0);
      tick();
    end
    chk("wd_last_busy_req", 32'(mem_req), 32'd1);
    tick();
    chk("wd_bus_err", 32'(bus_err), 32'd1);
    chk("wd_req_drop", 32'(mem_req), 32'd0);
    chk("wd_stall_release", 32'(stall), 32'd0);
    chk("wd_mdo", mdo, model_mdo);
    tick();
    chk("wd_bus_err_clr", 32'(bus_err), 32'd0);
    clear_inputs();
    tick();
    chk("wd_idle_req", 32'(mem_req), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      chk("wait_req", 32'(mem_req), 32'd1);
      chk("wait_stall", 32'(stall), 32'd1);
      chk("wait_bus_err", 32'(bus_err), 32'd0);
      tick();
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h0F0F_1234;
    model_mdo = 32'h0F0F_1234;
    exp_q.push_back(model_mdo);
    tick();
    chk("wait_done_req", 32'(mem_req), 32'd0);
    chk("wait_done_mdo", mdo, exp_q.pop_front());
    chk("wait_bus_err_done", 32'(bus_err), 32'd0);
    clear_inputs();
    tick();
    tick();
    chk("wait_idle_req", 32'(mem_req), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
